// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared state encoding and SPI-mode helpers for spi_adc_sampler.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONVST = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SHIFT  = 2'd3
  } state_t;

  // Clock polarity: SCLK idle level.
  function automatic logic cpol(input int mode);
    return ((mode / 2) % 2) != 0;
  endfunction

  // Clock phase: 0 samples on leading edges, 1 on trailing edges.
  function automatic logic cpha(input int mode);
    return (mode % 2) != 0;
  endfunction

  // Clock cycles from the trigger edge until the result is offered.
  function automatic int txn_len(input int convst_cyc, input int conv_wait,
                                 input int width, input int clk_div);
    return 1 + convst_cyc + conv_wait + 2 * width * clk_div;
  endfunction

endpackage

// File: rtl/spi_adc_sampler_sclk_divider.sv
// sclk_divider: SCLK half-period timer. Strobes once every CLK_DIV cycles while
// running and reports whether the coming toggle leaves the idle level.
module sclk_divider #(
  parameter int   CLK_DIV = 3,
  parameter logic CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_sclk,
  output logic o_toggle,
  output logic o_leading
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  // Half-period counter, held at zero outside SHIFT so the first half-period is full length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (!i_run || w_wrap) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  assign o_toggle  = i_run && w_wrap;
  assign o_leading = (i_sclk == CPOL);

endmodule

// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: drives a shared CONVST/SCLK to NUM_CH simultaneous-sampling
// ADCs, shifts in all MISO lines MSB-first and offers each result set through a
// valid/ready output register with sticky overrun.
module spi_adc_sampler
  import spi_adc_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int NUM_CH      = 1,
  parameter int SPI_MODE    = 1,
  parameter int CLK_DIV     = 3,
  parameter int CONVST_CYC  = 1,
  parameter int CONV_WAIT   = 0,
  parameter int CONV_PERIOD = 230
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    free_run,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       miso,
  output logic                    convst,
  output logic                    sclk,
  output logic                    busy,
  output logic [NUM_CH*WIDTH-1:0] data,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam logic CPOL      = cpol(SPI_MODE);
  localparam logic CPHA      = cpha(SPI_MODE);
  localparam int   TXN_LEN   = txn_len(CONVST_CYC, CONV_WAIT, WIDTH, CLK_DIV);
  localparam int   NUM_EDGES = 2 * WIDTH;
  localparam int   PER_W     = (CONV_PERIOD > 2) ? $clog2(CONV_PERIOD) : 1;
  localparam int   CYC_MAX   = (CONVST_CYC > CONV_WAIT) ? CONVST_CYC : CONV_WAIT;
  localparam int   CYC_W     = $clog2(CYC_MAX + 1);
  localparam int   EDGE_W    = $clog2(NUM_EDGES + 1);

  localparam logic [PER_W-1:0]  PER_LAST    = PER_W'(CONV_PERIOD - 1);
  localparam logic [CYC_W-1:0]  CONVST_LAST = CYC_W'(CONVST_CYC - 1);
  localparam logic [CYC_W-1:0]  WAIT_LAST   = CYC_W'(CONV_WAIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(NUM_EDGES - 1);

  if (CONV_PERIOD <= TXN_LEN + 1 || WIDTH < 2 || NUM_CH < 1 || CLK_DIV < 1 ||
      CONVST_CYC < 1 || SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_params
    $error("spi_adc_sampler: illegal parameter set (CONV_PERIOD too short or out-of-range value)");
  end

  state_t                       r_state, w_state_nxt;
  logic [PER_W-1:0]             r_period;
  logic [CYC_W-1:0]             r_cyc;
  logic [EDGE_W-1:0]            r_edges;
  logic                         r_sclk, r_convst, r_busy, r_valid, r_overrun;
  logic [NUM_CH-1:0][WIDTH-1:0] r_shift, w_shift_nxt;
  logic [NUM_CH*WIDTH-1:0]      r_data;
  logic                         w_tick, w_trigger, w_done, w_run;
  logic                         w_toggle, w_leading, w_sample;

  // Conversion period counter; restarts from zero whenever the block is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_period <= '0;
    else if (!enable || r_period == PER_LAST) r_period <= '0;
    else                                     r_period <= r_period + 1'b1;
  end

  assign w_tick    = enable && (r_period == PER_LAST);
  assign w_trigger = enable && (free_run ? w_tick : start);
  assign w_run     = (r_state == ST_SHIFT);

  sclk_divider #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_sclk    (r_sclk),
    .o_toggle  (w_toggle),
    .o_leading (w_leading)
  );

  // Next-state decode; completion coincides with the final SCLK toggle.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_trigger) w_state_nxt = ST_CONVST;
      ST_CONVST: if (r_cyc == CONVST_LAST) w_state_nxt = (CONV_WAIT == 0) ? ST_SHIFT : ST_WAIT;
      ST_WAIT:   if (r_cyc == WAIT_LAST) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_toggle && r_edges == EDGE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, phase counters and registered CONVST/SCLK/busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cyc    <= '0;
      r_edges  <= '0;
      r_sclk   <= CPOL;
      r_convst <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_convst <= (w_state_nxt == ST_CONVST);
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_state_nxt != r_state)                        r_cyc <= '0;
      else if (r_state == ST_CONVST || r_state == ST_WAIT) r_cyc <= r_cyc + 1'b1;
      if (r_state != ST_SHIFT) r_edges <= '0;
      else if (w_toggle)       r_edges <= r_edges + 1'b1;
      if (w_toggle) r_sclk <= ~r_sclk;
    end
  end

  assign w_sample = w_toggle && (CPHA ? !w_leading : w_leading);

  // Shift-left capture of every MISO line on the edge that reaches the sampling level.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_sample) begin
      for (int k = 0; k < NUM_CH; k++) begin
        w_shift_nxt[k] = {r_shift[k][WIDTH-2:0], miso[k]};
      end
    end
  end

  // Shift registers; a reset mid-transfer discards the partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_shift <= '0;
    else      r_shift <= w_shift_nxt;
  end

  // Result register: load when empty or drained this cycle, otherwise keep the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_done && (!r_valid || data_ready)) begin
      r_data  <= w_shift_nxt;
      r_valid <= 1'b1;
    end else if (r_valid && data_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    r_overrun <= 1'b0;
    else if (w_done && r_valid && !data_ready)   r_overrun <= 1'b1;
    else if (overrun_clr)                        r_overrun <= 1'b0;
  end

  assign convst     = r_convst;
  assign sclk       = r_sclk;
  assign busy       = r_busy;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_adc_sampler.sv
// tb_spi_adc_sampler: three sampler instances (1ch mode 1 defaults, 3ch mode 0,
// 3ch mode 3 with longer CONVST and a WAIT phase) sharing control inputs, each
// fed by a behavioural ADC that shifts on the non-sampling SCLK edge.
module tb_spi_adc_sampler;
  localparam int W = 10;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, free_run = 1'b0, start = 1'b0;
  logic data_ready = 1'b1, overrun_clr = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]     m0;
  logic [2:0]     m1, m2;
  logic           cv0, cv1, cv2, sc0, sc1, sc2, bz0, bz1, bz2, dv0, dv1, dv2, ov0, ov1, ov2;
  logic [W-1:0]   d0;
  logic [3*W-1:0] d1, d2;

  int checks = 0, errors = 0;
  logic [W-1:0]   v0 = '0;
  logic [W-1:0]   v3 [3];
  logic [W-1:0]   q0 [$];
  logic [3*W-1:0] q1 [$], q2 [$];
  int lead0 = 0, trail0 = 0, lead1 = 0, trail1 = 0, lead2 = 0, trail2 = 0;
  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b1;

  spi_adc_sampler u0 (
    .clk(clk), .rst(rst), .enable(enable), .free_run(free_run), .start(start),
    .miso(m0), .convst(cv0), .sclk(sc0), .busy(bz0), .data(d0), .data_valid(dv0),
    .data_ready(data_ready), .overrun(ov0), .overrun_clr(overrun_clr));

  spi_adc_sampler #(.NUM_CH(3), .SPI_MODE(0)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .free_run(free_run), .start(start),
    .miso(m1), .convst(cv1), .sclk(sc1), .busy(bz1), .data(d1), .data_valid(dv1),
    .data_ready(data_ready), .overrun(ov1), .overrun_clr(overrun_clr));

  spi_adc_sampler #(.NUM_CH(3), .SPI_MODE(3), .CONVST_CYC(2), .CONV_WAIT(4)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .free_run(free_run), .start(start),
    .miso(m2), .convst(cv2), .sclk(sc2), .busy(bz2), .data(d2), .data_valid(dv2),
    .data_ready(data_ready), .overrun(ov2), .overrun_clr(overrun_clr));

  // ADC edge counters: restart on CONVST, count leading/trailing SCLK edges.
  always @(cv0 or sc0) begin
    if (cv0) begin lead0 = 0; trail0 = 0; end
    else if (rst && sc0 !== p0) begin if (sc0) lead0++; else trail0++; end
    p0 = sc0;
  end
  always @(cv1 or sc1) begin
    if (cv1) begin lead1 = 0; trail1 = 0; end
    else if (rst && sc1 !== p1) begin if (sc1) lead1++; else trail1++; end
    p1 = sc1;
  end
  always @(cv2 or sc2) begin
    if (cv2) begin lead2 = 0; trail2 = 0; end
    else if (rst && sc2 !== p2) begin if (!sc2) lead2++; else trail2++; end
    p2 = sc2;
  end

  // CPHA=1 ADCs present bit W-n after leading edge n; CPHA=0 after trailing edge n-1.
  always_comb begin
    m0[0] = (lead0 >= 1 && lead0 <= W) ? v0[W-lead0] : 1'b0;
    for (int k = 0; k < 3; k++) begin
      m1[k] = (trail1 >= 0 && trail1 < W) ? v3[k][W-1-trail1] : 1'b0;
      m2[k] = (lead2 >= 1 && lead2 <= W) ? v3[k][W-lead2] : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cv0, cv1, cv2, bz0, bz1, bz2, dv0, dv1, dv2, ov0, ov1, ov2} !== 12'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want all zero",
               {cv0, cv1, cv2, bz0, bz1, bz2, dv0, dv1, dv2, ov0, ov1, ov2});
    end
    checks++;
    if ({sc0, sc1, sc2} !== 3'b001) begin
      errors++; $display("FAIL reset_sclk got %b want 001", {sc0, sc1, sc2});
    end
    checks++;
    if (d0 !== '0 || d1 !== '0 || d2 !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h want 0", d0, d1, d2);
    end
    rst = 1'b1; enable = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int conv_first, conv_n, tog, busy_n, vld_n, vld_k, vld2_k;
    logic prev;
    logic [W-1:0] e0;
    logic [3*W-1:0] e3;
    v0 = 10'h2B5; v3[0] = 10'h3FF; v3[1] = 10'h000; v3[2] = 10'h155;
    q0.push_back(v0);
    q1.push_back({v3[2], v3[1], v3[0]});
    q2.push_back({v3[2], v3[1], v3[0]});
    conv_first = -1; conv_n = 0; tog = 0; busy_n = 0; vld_n = 0; vld_k = -1; vld2_k = -1;
    data_ready = 1'b1; free_run = 1'b0;
    prev = sc0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 90; k++) begin
      if (k > 0) tick();
      if (cv0) begin conv_n++; if (conv_first < 0) conv_first = k; end
      if (sc0 !== prev) tog++;
      prev = sc0;
      if (bz0) busy_n++;
      if (dv0) begin
        vld_n++; vld_k = k; checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL single_extra0 got %h want none", d0); end
        else begin
          e0 = q0.pop_front();
          if (d0 !== e0) begin errors++; $display("FAIL single_data0 got %h want %h", d0, e0); end
        end
      end
      if (dv1) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL single_extra1 got %h want none", d1); end
        else begin
          e3 = q1.pop_front();
          if (d1 !== e3) begin errors++; $display("FAIL single_data1 got %h want %h", d1, e3); end
        end
      end
      if (dv2) begin
        vld2_k = k; checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL single_extra2 got %h want none", d2); end
        else begin
          e3 = q2.pop_front();
          if (d2 !== e3) begin errors++; $display("FAIL single_data2 got %h want %h", d2, e3); end
        end
      end
    end
    checks++;
    if (conv_first != 0 || conv_n != 1) begin
      errors++; $display("FAIL single_convst got first=%0d n=%0d want first=0 n=1", conv_first, conv_n);
    end
    checks++;
    if (tog != 20) begin errors++; $display("FAIL single_toggles got %0d want 20", tog); end
    checks++;
    if ({sc0, sc1, sc2} !== 3'b001) begin
      errors++; $display("FAIL single_sclk_idle got %b want 001", {sc0, sc1, sc2});
    end
    checks++;
    if (busy_n != 61) begin errors++; $display("FAIL single_busy got %0d want 61", busy_n); end
    checks++;
    if (vld_n != 1 || vld_k != 61) begin
      errors++; $display("FAIL single_latency got n=%0d k=%0d want n=1 k=61", vld_n, vld_k);
    end
    checks++;
    if (vld2_k != 66) begin errors++; $display("FAIL single_latency2 got %0d want 66", vld2_k); end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++; $display("FAIL single_missing got %0d/%0d want 0/0", q1.size(), q2.size());
    end
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL single_overrun got %b want 0", ov0); end
  endtask

  task automatic test_free_run();
    int last, n;
    logic cvp;
    logic [W-1:0] e0;
    v0 = 10'h1E7; data_ready = 1'b1; free_run = 1'b1;
    last = -1; n = 0; cvp = cv0;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (cv0 && !cvp) q0.push_back(v0);
      cvp = cv0;
      start = (k % 7 == 0);
      if (dv0) begin
        checks++;
        e0 = (q0.size() > 0) ? q0.pop_front() : ~v0;
        if (d0 !== e0) begin errors++; $display("FAIL freerun_data got %h want %h", d0, e0); end
        if (last >= 0) begin
          checks++;
          if (k - last != 230) begin errors++; $display("FAIL freerun_period got %0d want 230", k - last); end
        end
        last = k; n++;
      end
    end
    start = 1'b0; free_run = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (dv0) begin
        checks++;
        e0 = (q0.size() > 0) ? q0.pop_front() : ~v0;
        if (d0 !== e0) begin errors++; $display("FAIL freerun_drain got %h want %h", d0, e0); end
      end
    end
    checks++;
    if (n < 3) begin errors++; $display("FAIL freerun_count got %0d want >=3", n); end
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL freerun_missing got %0d want 0", q0.size()); end
  endtask

  task automatic test_overrun();
    int k0, ovk, ov_n;
    logic held;
    logic [W-1:0] e0;
    v0 = 10'h2B5; data_ready = 1'b0; overrun_clr = 1'b0; start = 1'b0; free_run = 1'b1;
    q0.push_back(10'h2B5);
    k0 = -1;
    for (int k = 0; k < 400 && k0 < 0; k++) begin tick(); if (dv0) k0 = k; end
    checks++;
    if (k0 < 0) begin errors++; $display("FAIL ovr_first got timeout want data_valid"); end
    else if (d0 !== 10'h2B5) begin errors++; $display("FAIL ovr_first got %h want 2b5", d0); end
    v0 = 10'h1C3;
    ovk = -1; held = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      tick();
      if (dv0 !== 1'b1 || d0 !== 10'h2B5) held = 1'b0;
      if (ov0 === 1'b1 && ovk < 0) ovk = k;
    end
    checks++;
    if (!held) begin errors++; $display("FAIL ovr_hold got %b/%h want 1/2b5", dv0, d0); end
    checks++;
    if (ovk != 230 || ov0 !== 1'b1) begin
      errors++; $display("FAIL ovr_set got k=%0d ov=%b want k=230 ov=1", ovk, ov0);
    end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ov0); end
    overrun_clr = 1'b1; ov_n = 0;
    for (int k = 0; k < 240; k++) begin tick(); if (ov0 === 1'b1) ov_n++; end
    overrun_clr = 1'b0; free_run = 1'b0;
    checks++;
    if (ov_n != 1) begin errors++; $display("FAIL ovr_set_wins got %0d cycles want 1", ov_n); end
    data_ready = 1'b1;
    checks++;
    e0 = (q0.size() > 0) ? q0.pop_front() : ~d0;
    if (dv0 !== 1'b1 || d0 !== e0) begin
      errors++; $display("FAIL ovr_deliver got %b/%h want 1/%h", dv0, d0, e0);
    end
    tick();
    checks++;
    if (dv0 !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b want 0", dv0); end
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [W-1:0] e0;
    v0 = 10'h0CA; data_ready = 1'b1; free_run = 1'b0;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (29) tick();
    rst = 1'b0; #1;
    checks++;
    if ({cv0, bz0, dv0, ov0, bz2} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b want 00000", {cv0, bz0, dv0, ov0, bz2});
    end
    checks++;
    if (sc0 !== 1'b0 || sc2 !== 1'b1) begin
      errors++; $display("FAIL rstmid_sclk got %b%b want 01", sc0, sc2);
    end
    checks++;
    if (d0 !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", d0); end
    tick(); tick();
    rst = 1'b1;
    tick();
    q0.push_back(v0);
    start = 1'b1; tick(); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (dv0) begin
        got = 1'b1; checks++;
        e0 = q0.pop_front();
        if (d0 !== e0) begin errors++; $display("FAIL rstmid_result got %h want %h", d0, e0); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_timeout got no data_valid want one"); end
  endtask

  task automatic test_enable_wait();
    int cnt;
    logic got;
    logic [3*W-1:0] e3;
    repeat (10) tick();
    v3[0] = 10'h3C0; v3[1] = 10'h0A5; v3[2] = 10'h111;
    q2.push_back({v3[2], v3[1], v3[0]});
    data_ready = 1'b1; free_run = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (!(bz2 === 1'b1 && cv2 === 1'b0 && sc2 === 1'b1)) begin
      errors++; $display("FAIL en_in_wait got busy=%b convst=%b sclk=%b want 1 0 1", bz2, cv2, sc2);
    end
    enable = 1'b0; free_run = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (dv2) begin
        got = 1'b1; checks++;
        e3 = q2.pop_front();
        if (d2 !== e3) begin errors++; $display("FAIL en_result got %h want %h", d2, e3); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL en_timeout got no data_valid want one"); end
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin tick(); if (cv0 || cv1 || cv2) cnt++; end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL en_idle got %0d convst cycles want 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_free_run();
    test_overrun();
    test_reset_mid();
    test_enable_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
